// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX boundary register with EX/MEM operand forwarding,
// immediate select and one-bubble load-use hazard insertion.
module ex_operand_stage #(
    parameter int REG_FILE_WIDTH = 32,
    parameter int REG_ADDR_W     = 5,
    parameter int CNT_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      dec_valid,
    output logic                      dec_ready,
    input  logic [5:0]                dec_op,
    input  logic [REG_ADDR_W-1:0]     dec_rd,
    input  logic [REG_ADDR_W-1:0]     dec_rs1,
    input  logic [REG_ADDR_W-1:0]     dec_rs2,
    input  logic                      dec_use_rs1,
    input  logic                      dec_use_rs2,
    input  logic [REG_FILE_WIDTH-1:0] dec_rs1_val,
    input  logic [REG_FILE_WIDTH-1:0] dec_rs2_val,
    input  logic                      dec_use_imm,
    input  logic [REG_FILE_WIDTH-1:0] dec_imm,
    input  logic                      dec_is_load,
    input  logic [REG_FILE_WIDTH-1:0] fwd_ex_result,
    input  logic                      mem_valid,
    input  logic                      mem_wen,
    input  logic [REG_ADDR_W-1:0]     mem_rd,
    input  logic [REG_FILE_WIDTH-1:0] mem_result,
    input  logic                      flush,
    input  logic                      ex_ready,
    output logic                      ex_valid,
    output logic [5:0]                ex_op,
    output logic [REG_FILE_WIDTH-1:0] ex_x,
    output logic [REG_FILE_WIDTH-1:0] ex_y,
    output logic [REG_ADDR_W-1:0]     ex_rd,
    output logic                      ex_wen,
    output logic                      ex_is_load,
    output logic [CNT_W-1:0]          bubble_cnt
);
    logic                      hazard, ex_hit, mem_hit;
    logic [REG_FILE_WIDTH-1:0] x_fwd, y_fwd;

    // A load's data only exists in MEM, so EX forwarding excludes loads.
    assign ex_hit  = ex_valid & ex_wen & ~ex_is_load;
    assign mem_hit = mem_valid & mem_wen;

    assign hazard = dec_valid & ex_valid & ex_is_load & ex_wen &
                    ((dec_use_rs1 & (dec_rs1 == ex_rd)) |
                     (dec_use_rs2 & ~dec_use_imm & (dec_rs2 == ex_rd)));

    assign dec_ready = flush | (ex_ready & ~hazard);

    assign x_fwd = (dec_rs1 == '0)                  ? '0 :
                   (ex_hit & (ex_rd == dec_rs1))    ? fwd_ex_result :
                   (mem_hit & (mem_rd == dec_rs1))  ? mem_result : dec_rs1_val;

    assign y_fwd = dec_use_imm                      ? dec_imm :
                   (dec_rs2 == '0)                  ? '0 :
                   (ex_hit & (ex_rd == dec_rs2))    ? fwd_ex_result :
                   (mem_hit & (mem_rd == dec_rs2))  ? mem_result : dec_rs2_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_op      <= '0;
            ex_x       <= '0;
            ex_y       <= '0;
            ex_rd      <= '0;
            ex_wen     <= 1'b0;
            ex_is_load <= 1'b0;
            bubble_cnt <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (ex_ready) begin
            if (hazard) begin
                ex_valid <= 1'b0;
                if (~&bubble_cnt) bubble_cnt <= bubble_cnt + CNT_W'(1);
            end else begin
                ex_valid   <= dec_valid;
                ex_op      <= dec_op;
                ex_x       <= x_fwd;
                ex_y       <= y_fwd;
                ex_rd      <= dec_rd;
                ex_wen     <= dec_rd != '0;
                ex_is_load <= dec_is_load;
            end
        end
    end
endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX boundary stage directly upstream of the ALU.
- Captures a decoded instruction and resolves its two ALU operands, using EX and MEM result forwarding and an immediate select.
- Detects load-use hazards and inserts one bubble for each.
- Presents a registered op/x/y/rd bundle to the ALU stage under a valid/ready handshake with flush.

Parameters:
- REG_FILE_WIDTH, 32, operand/result width; default taken from the header.
- REG_ADDR_W, 5, register index width; index 0 is hard-wired zero and never forwarded.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- dec_valid  in  1  decode holds a valid instruction
- dec_ready  out  1  stage accepts decode instruction this cycle
- dec_op  in  6  ALU opcode
- dec_rd / dec_rs1 / dec_rs2  in  REG_ADDR_W each  destination / source register indices
- dec_use_rs1 / dec_use_rs2  in  1 each  source actually read
- dec_rs1_val / dec_rs2_val  in  REG_FILE_WIDTH each  register-file read data; the file is write-before-read, so no WB forward is needed
- dec_use_imm  in  1  y operand comes from dec_imm instead of rs2
- dec_imm  in  REG_FILE_WIDTH  sign-extended immediate
- dec_is_load  in  1  instruction is a load
- fwd_ex_result  in  REG_FILE_WIDTH  ALU output (w) for the instruction currently in ex_* registers
- mem_valid / mem_wen  in  1 each  MEM-stage instruction valid / writes a register
- mem_rd  in  REG_ADDR_W  MEM-stage destination register
- mem_result  in  REG_FILE_WIDTH  MEM-stage final result, including load data
- flush  in  1  kill the younger instruction (branch/exception)
- ex_ready  in  1  ALU stage can accept a new bundle
- ex_valid  out  1  bundle valid
- ex_op  out  6  opcode
- ex_x / ex_y  out  REG_FILE_WIDTH each  operands
- ex_rd  out  REG_ADDR_W  destination register
- ex_wen  out  1  bundle writes a register (rd != 0)
- ex_is_load  out  1  bundle is a load
- bubble_cnt  out  CNT_W  count of load-use bubbles inserted

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, including ex_valid=0 and bubble_cnt=0. Deasserting rst_n mid-operation discards all held state.
- Hazard:
  - hazard = dec_valid & ex_valid & ex_is_load & ex_wen & ((dec_use_rs1 & rs1==ex_rd) | (dec_use_rs2 & ~dec_use_imm & rs2==ex_rd)).
  - ex_rd != 0 is implied by ex_wen.
- dec_ready = flush | (ex_ready & ~hazard), combinational.
- Forwarding for each source s, evaluated at capture:
  - If s==0: value 0.
  - Else if ex_valid & ex_wen & ~ex_is_load & ex_rd==s: fwd_ex_result.
  - Else if mem_valid & mem_wen & mem_rd==s: mem_result.
  - Else: the register-file value.
  - EX has priority over MEM.
- ex_x = fwd(rs1). ex_y = dec_use_imm ? dec_imm : fwd(rs2).
- Register update each rising clk, in this priority order:
  1. flush: ex_valid<=0. Other fields are don't-care but held. The decode instruction is consumed and dropped.
  2. ~ex_ready: all ex_* registers hold.
  3. hazard: ex_valid<=0 (bubble); bubble_cnt += 1, saturating at all-ones. Decode holds its instruction.
  4. Otherwise: capture the decode bundle; ex_valid<=dec_valid; ex_wen<=(dec_rd!=0).
- Latency: 1 cycle from decode acceptance to ex_valid. Load-use costs exactly 1 bubble; on the following cycle the load is in MEM and is forwarded via mem_result.
- Simultaneous flush and hazard: flush wins and no bubble is counted. Simultaneous flush and ~ex_ready: flush still clears ex_valid.
- Throughput: 1 instruction/cycle with no hazards and ex_ready=1.

Test Plan:
- Reset mid-stream: rst_n=0 asynchronously while ex_valid=1 -> ex_valid=0 and bubble_cnt=0 immediately, with no clk edge.
- EX forward: bundle ADD r3 in EX (fwd_ex_result=0x11); decode ADD r4,r3,r2 with rf r3=0x5, r2=0x2 -> next cycle ex_x=0x11, ex_y=0x2.
- MEM vs EX priority: EX rd=r3 (0x11), MEM rd=r3 (0x22); decode reads r3 -> ex_x=0x11. Same case with EX rd=r7 -> ex_x=0x22.
- Load-use: LD r5 in EX; decode SUB r6,r5,r1 -> dec_ready=0, next ex_valid=0, bubble_cnt=1. The cycle after, with mem_rd=r5 and mem_result=0xABCD, gives ex_x=0xABCD.
- r0 and immediate: decode OR r1,r0,imm=0x7FF with EX rd=0 -> ex_x=0, ex_y=0x7FF, ex_wen=1. A load writing r0 never triggers a hazard.
- Stall plus flush: ex_ready=0 for 3 cycles -> ex_* held, dec_ready=0. Then flush=1 with hazard active -> ex_valid=0, dec_ready=1, bubble_cnt unchanged.
